instr_loader: RTL
=================

INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 SHALL have parameter width, default 9, giving the address and instruction-word width.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port load_req  input  1  request to load a program, sampled in IDLE only.
REQ-005 SHALL have port load_base  input  width  first instruction-memory address, sampled with load_req.
REQ-006 SHALL have port load_len  input  width  number of words to load, sampled with load_req.
REQ-007 SHALL have port abort  input  1  cancels an in-progress load.
REQ-008 SHALL have port data_valid  input  1  source presents a word on data_in.
REQ-009 SHALL have port data_in  input  width  instruction word from the source.
REQ-010 SHALL have port data_ready  output  1  loader accepts data_in this cycle.
REQ-011 SHALL have port wr_en  output  1  instruction-memory write strobe.
REQ-012 SHALL have port wr_addr  output  width  instruction-memory write address.
REQ-013 SHALL have port wr_data  output  width  instruction-memory write data.
REQ-014 SHALL have port start  output  1  fetch-unit start pulse.
REQ-015 SHALL have port start_addr  output  width  PC value loaded by start.
REQ-016 SHALL have port busy  output  1  high in LOAD and LAUNCH.
REQ-017 SHALL have port done  output  1  high in DONE.

Function
REQ-018 SHALL implement states IDLE, LOAD, LAUNCH, DONE.
REQ-019 IDLE: on load_req=1, SHALL latch load_base into base and load_len into len, clear count, and go to LOAD when len!=0, else to LAUNCH.
REQ-020 LOAD: SHALL drive data_ready=1; a handshake occurs when data_valid and data_ready are both 1.
REQ-021 On each handshake, the next cycle SHALL have wr_en=1, wr_addr=(base+count) mod 2^width, wr_data=data_in as captured; count SHALL increment.
REQ-022 wr_en SHALL be 0 in every cycle that does not follow a handshake; this gives one write per accepted word and 1-cycle latency.
REQ-023 The handshake with count==len-1 SHALL move to LAUNCH; data_ready SHALL be 0 from that next cycle on.
REQ-024 Address arithmetic SHALL wrap modulo 2^width; e.g. base=510, len=3 writes 510, 511, 0.
REQ-025 LAUNCH: SHALL assert start=1 for exactly one cycle with start_addr=base, then go to DONE.
REQ-026 DONE: SHALL hold done=1 and start_addr=base until load_req=0, then go to IDLE.
REQ-027 abort=1 in LOAD SHALL move to IDLE next cycle with no start pulse; a write already registered for that cycle SHALL still complete; abort SHALL have priority over a simultaneous final handshake.
REQ-028 abort SHALL be ignored in IDLE, LAUNCH and DONE.
REQ-029 load_req and load_base/load_len changes SHALL be ignored outside IDLE.
REQ-030 Outside LAUNCH, start SHALL be 0; outside LOAD, data_ready SHALL be 0.

Reset
REQ-031 reset=1 SHALL immediately force state=IDLE, count=0, base=0, len=0, wr_en=0, wr_addr=0, wr_data=0, start=0, start_addr=0, data_ready=0, busy=0, done=0.
REQ-032 Reset mid-LOAD SHALL discard the load: no further writes and no start pulse.

Structure
REQ-033 The state enum and the default width constant SHALL be in a shared package loader_pkg.
REQ-034 SHALL be one module with no sub-modules; the counter and FSM are inline.

Verification
REQ-035 Basic load: base=0, len=4, words 0x011,0x022,0x033,0x044 back-to-back -> writes at addr 0..3, then a 1-cycle start with start_addr=0, then done=1.
REQ-036 Stalled source: len=3, data_valid toggling 1,0,0,1,0,1 -> exactly 3 writes, each 1 cycle after its handshake, in order.
REQ-037 Wrap: base=510, len=3 -> wr_addr 510, 511, 0; start_addr=510.
REQ-038 Zero length: len=0 -> no wr_en, start pulse 2 cycles after load_req, start_addr=base.
REQ-039 Abort: abort after 2 of 5 words -> 2 writes, no start, IDLE next cycle, new load_req accepted.
REQ-040 Async reset asserted mid-LOAD between clock edges -> all outputs 0 before the next edge; no start after release.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and defaults for the instruction loader.
package loader_pkg;
  localparam int DEFAULT_WIDTH = 9;
  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    LAUNCH,
    DONE
  } state_t;
endpackage

// File: rtl/instr_loader.sv
// Streams a program into instruction memory,
// then pulses the fetch unit with the base PC.
module instr_loader
  import loader_pkg::*;
#(
  parameter int width = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_req,
  input  logic [width-1:0] load_base,
  input  logic [width-1:0] load_len,
  input  logic             abort,
  input  logic             data_valid,
  input  logic [width-1:0] data_in,
  output logic             data_ready,
  output logic             wr_en,
  output logic [width-1:0] wr_addr,
  output logic [width-1:0] wr_data,
  output logic             start,
  output logic [width-1:0] start_addr,
  output logic             busy,
  output logic             done
);

  localparam logic [width-1:0] one =
    {{(width-1){1'b0}}, 1'b1};

  state_t state, state_nx;

  logic [width-1:0] base;
  logic [width-1:0] len;
  logic [width-1:0] count;
  logic             accept;
  logic             last;

  // abort cancels the handshake in its own cycle
  assign accept = (state == LOAD) && data_valid
                  && !abort;
  assign last   = (count == len - one);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (load_req) begin
          state_nx = (load_len != '0) ? LOAD
                                      : LAUNCH;
        end
      end
      LOAD: begin
        if (abort) begin
          state_nx = IDLE;
        end else if (accept && last) begin
          state_nx = LAUNCH;
        end
      end
      LAUNCH: state_nx = DONE;
      DONE: begin
        if (!load_req) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base    <= '0;
      len     <= '0;
      count   <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= accept;
      if (state == IDLE && load_req) begin
        base  <= load_base;
        len   <= load_len;
        count <= '0;
      end
      if (accept) begin
        wr_addr <= base + count;
        wr_data <= data_in;
        count   <= count + one;
      end
    end
  end

  assign data_ready = (state == LOAD);
  assign busy       = (state == LOAD)
                      || (state == LAUNCH);
  assign done       = (state == DONE);
  assign start      = (state == LAUNCH);
  assign start_addr = base;

endmodule
